// File: rtl/one2two_demux.sv
// AXI4-Stream 1:2 video demultiplexer with a single registered output stage.
// The route is re-sampled only on accepted start-of-frame beats.
module one2two_demux #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic [width-1:0] m0_axis_tdata,
    output logic             m0_axis_tvalid,
    input  logic             m0_axis_tready,
    output logic             m0_axis_tuser,
    output logic             m0_axis_tlast,
    output logic [width-1:0] m1_axis_tdata,
    output logic             m1_axis_tvalid,
    input  logic             m1_axis_tready,
    output logic             m1_axis_tuser,
    output logic             m1_axis_tlast,
    output logic             route,
    output logic [15:0]      drop_count
);

    typedef enum logic [0:0] {StWaitSof, StPass} state_e;

    state_e             state_q, state_d;
    logic               route_q, route_d;
    logic [15:0]        drop_q, drop_d;
    logic               valid_q, valid_d;
    logic [width-1:0]   data_q, data_d;
    logic               user_q, user_d;
    logic               last_q, last_d;
    logic               dest_q, dest_d;

    logic out_ready;
    logic accept;

    // Only the currently addressed downstream can release the register.
    assign out_ready     = dest_q ? m1_axis_tready : m0_axis_tready;
    assign s_axis_tready = !reset && (!valid_q || out_ready);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        drop_d  = drop_q;
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        last_d  = last_q;
        dest_d  = dest_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (state_q == StWaitSof && !s_axis_tuser) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else begin
                valid_d = 1'b1;
                data_d  = s_axis_tdata;
                user_d  = s_axis_tuser;
                last_d  = s_axis_tlast;
                if (s_axis_tuser) begin
                    // New frame: the sel value on this very beat decides its route.
                    route_d = sel;
                    dest_d  = sel;
                    state_d = StPass;
                end else begin
                    dest_d  = route_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWaitSof;
            route_q <= 1'b0;
            drop_q  <= 16'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
            dest_q  <= dest_d;
        end
    end

    assign m0_axis_tvalid = valid_q && !dest_q;
    assign m1_axis_tvalid = valid_q && dest_q;
    assign m0_axis_tdata  = data_q;
    assign m1_axis_tdata  = data_q;
    assign m0_axis_tuser  = user_q;
    assign m1_axis_tuser  = user_q;
    assign m0_axis_tlast  = last_q;
    assign m1_axis_tlast  = last_q;
    assign route          = route_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_one2two_demux.sv
// Self-checking bench for one2two_demux: transaction-queue reference model,
// directed frame scenarios and randomized traffic.
module tb_one2two_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [31:0] m0_tdata, m1_tdata;
    logic        m0_tvalid, m0_tready, m0_tuser, m0_tlast;
    logic        m1_tvalid, m1_tready, m1_tuser, m1_tlast;
    logic        route;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    one2two_demux #(.width(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tuser   (s_tuser),
        .s_axis_tlast   (s_tlast),
        .m0_axis_tdata  (m0_tdata),
        .m0_axis_tvalid (m0_tvalid),
        .m0_axis_tready (m0_tready),
        .m0_axis_tuser  (m0_tuser),
        .m0_axis_tlast  (m0_tlast),
        .m1_axis_tdata  (m1_tdata),
        .m1_axis_tvalid (m1_tvalid),
        .m1_axis_tready (m1_tready),
        .m1_axis_tuser  (m1_tuser),
        .m1_axis_tlast  (m1_tlast),
        .route          (route),
        .drop_count     (drop_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
        logic        dest;
    } beat_t;

    // Reference model: beats accepted but not yet handed off, in order.
    beat_t inflight[$];
    bit    m_route;
    bit    m_pass;
    int    m_drop;
    int    total;
    int    bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check outputs at the falling edge, then advance the model over the next rising edge.
    task automatic cycle(output bit acc);
        bit    full, dready, exp_tready, hs;
        beat_t f;
        @(negedge clk);
        full = inflight.size() > 0;
        f    = full ? inflight[0] : '0;
        dready     = f.dest ? m1_tready : m0_tready;
        exp_tready = !reset && (!full || dready);
        check("s_tready", s_tready, exp_tready);
        check("m0_tvalid", m0_tvalid, full && !f.dest);
        check("m1_tvalid", m1_tvalid, full && f.dest);
        if (full) begin
            check("m0_tdata", m0_tdata, f.data);
            check("m1_tdata", m1_tdata, f.data);
            check(f.dest ? "m1_tuser" : "m0_tuser", f.dest ? m1_tuser : m0_tuser, f.user);
            check(f.dest ? "m1_tlast" : "m0_tlast", f.dest ? m1_tlast : m0_tlast, f.last);
        end
        check("route", route, m_route);
        check("drop_count", drop_count, m_drop);
        hs  = full && dready;
        acc = s_tvalid && exp_tready;
        if (reset) begin
            inflight.delete();
            m_route = 1'b0;
            m_pass  = 1'b0;
            m_drop  = 0;
        end else begin
            if (hs) void'(inflight.pop_front());
            if (acc) begin
                if (!m_pass && !s_tuser) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    if (s_tuser) begin
                        m_route = sel;
                        m_pass  = 1'b1;
                    end
                    inflight.push_back('{data: s_tdata, user: s_tuser, last: s_tlast,
                                         dest: m_route});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        s_tvalid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic send(input logic [31:0] d, input bit u, input bit l, input bit s,
                        output int waits);
        bit acc;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        sel      = s;
        waits    = 0;
        forever begin
            cycle(acc);
            if (acc) break;
            waits++;
            if (waits > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    // 4x2 frame: tuser on beat 0, tlast on beats 3 and 7; sel switches to sel_b from beat sw.
    task automatic frame(input logic [31:0] base, input bit sel_a, input bit sel_b,
                         input int sw, output int bubbles);
        int w;
        bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            send(base + i, i == 0, (i == 3) || (i == 7), (i >= sw) ? sel_b : sel_a, w);
            bubbles += w;
        end
    endtask

    initial begin
        int w;
        int bub;
        bit acc;
        total     = 0;
        bad       = 0;
        m_route   = 1'b0;
        m_pass    = 1'b0;
        m_drop    = 0;
        reset     = 1'b1;
        sel       = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tuser   = 1'b0;
        s_tlast   = 1'b0;
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        @(posedge clk);
        #1;
        cycle(acc);
        reset = 1'b0;
        idle(2);

        // Reset recovery with a pending beat in the register.
        m0_tready = 1'b0;
        send(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, w);
        idle(1);
        reset = 1'b1;
        cycle(acc);
        reset = 1'b0;
        check("rst_m0_tdata", m0_tdata, 32'd0);
        check("rst_m1_tdata", m1_tdata, 32'd0);
        check("rst_m0_tuser", m0_tuser, 32'd0);
        check("rst_m0_tlast", m0_tlast, 32'd0);
        check("rst_route", route, 32'd0);
        check("rst_drop", drop_count, 32'd0);
        m0_tready = 1'b1;
        for (int i = 0; i < 5; i++) send(32'h100 + i, 1'b0, 1'b0, 1'b0, w);
        send(32'h200, 1'b1, 1'b0, 1'b1, w);
        check("drop5", drop_count, 32'd5);
        check("sof_m1_valid", m1_tvalid, 32'd1);
        check("sof_m1_user", m1_tuser, 32'd1);
        check("sof_m0_quiet", m0_tvalid, 32'd0);
        idle(2);

        // Streaming on m0 with no bubbles.
        frame(32'h0, 1'b0, 1'b0, 8, bub);
        check("stream_bubbles", bub, 32'd0);
        idle(2);

        // Mid-frame sel change is ignored until the next frame.
        frame(32'h10, 1'b0, 1'b1, 3, bub);
        check("midsel_route", route, 32'd0);
        frame(32'h20, 1'b1, 1'b1, 0, bub);
        check("next_frame_route", route, 32'd1);
        idle(2);

        // Back-pressure on m0 while m1_tready toggles.
        fork
            frame(32'h0, 1'b0, 1'b0, 8, bub);
            begin
                repeat (3) @(posedge clk);
                #2;
                m0_tready = 1'b0;
                repeat (3) begin
                    m1_tready = ~m1_tready;
                    @(posedge clk);
                    #2;
                end
                m0_tready = 1'b1;
                m1_tready = 1'b1;
            end
        join
        check("bp_bubbles", bub, 32'd3);
        idle(2);

        // Route change while the last beat of frame A is stuck on m0.
        for (int i = 0; i < 8; i++) send(32'h30 + i, i == 0, (i == 3) || (i == 7), 1'b0, w);
        m0_tready = 1'b0;
        fork
            send(32'h40, 1'b1, 1'b0, 1'b1, w);
            begin
                repeat (3) @(posedge clk);
                #2;
                m0_tready = 1'b1;
            end
        join
        check("full_switch_wait", w, 32'd3);
        check("full_switch_m1", m1_tvalid, 32'd1);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 399) == 0);
            s_tvalid  = $urandom_range(0, 3) != 0;
            s_tdata   = $urandom;
            s_tuser   = $urandom_range(0, 15) == 0;
            s_tlast   = $urandom_range(0, 7) == 0;
            sel       = $urandom_range(0, 1) == 1;
            m0_tready = $urandom_range(0, 3) != 0;
            m1_tready = $urandom_range(0, 3) != 0;
            cycle(acc);
        end
        reset     = 1'b0;
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        idle(3);

        // Drop counter saturation.
        reset = 1'b1;
        idle(1);
        reset    = 1'b0;
        s_tvalid = 1'b1;
        s_tuser  = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            s_tdata = n;
            cycle(acc);
        end
        s_tvalid = 1'b0;
        idle(1);
        check("drop_sat", drop_count, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
